// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver (8E1 when UART_RX_PARITY_EN is defined) feeding a FWFT byte FIFO.
// Latency: a byte is pushed in the mid-stop sample cycle; rx_valid rises on the next cycle.
// Backpressure: rx_ready low holds bytes in the FIFO; a good byte arriving while full is dropped and pulses overrun.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 140000000,
    parameter int SCLK_HZ    = 115200,
    parameter int DEPTH_FIFO = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);
    localparam int DIV     = CLK_HZ / SCLK_HZ;
    localparam int HALF    = DIV / 2;
    localparam int CNT_W   = $clog2(DIV + 1);
    localparam int ENTRIES = 1 << DEPTH_FIFO;
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]      CNT_BIT  = CNT_W'(DIV - 1);
    localparam logic [DEPTH_FIFO:0]   CNT_FULL = (DEPTH_FIFO + 1)'(ENTRIES);
    localparam logic [DEPTH_FIFO:0]   OCC_ONE  = (DEPTH_FIFO + 1)'(1);
    localparam logic [DEPTH_FIFO-1:0] PTR_ONE  = DEPTH_FIFO'(1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                state, state_nxt;
    logic                  rxd_s1, rxd_s2, rxd_prev;
    logic                  fall;
    logic [CNT_W-1:0]      cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            shreg;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit;
`endif
    logic                  half_hit, bit_hit, stop_hit, frame_ok, push_req, bad_frame;
    logic [7:0]            mem [ENTRIES];
    logic [DEPTH_FIFO-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_FIFO:0]   occ;
    logic                  full, pop, push;

    // Idle-high line: synchronizer resets to 1 so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_s1   <= uart_rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
        end
    end

    assign fall     = rxd_prev && !rxd_s2;
    assign half_hit = (cnt == CNT_HALF);
    assign bit_hit  = (cnt == CNT_BIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (fall) state_nxt = S_START;
            S_START:  if (half_hit) state_nxt = rxd_s2 ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (bit_hit && bit_idx == 3'd7) state_nxt = S_PARITY;
            S_PARITY: if (bit_hit) state_nxt = S_STOP;
`else
            S_DATA:   if (bit_hit && bit_idx == 3'd7) state_nxt = S_STOP;
`endif
            S_STOP:   if (bit_hit) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Leaving STOP at mid-bit lets a start edge half a bit later be caught.
    always_comb begin
        busy     = (state != S_IDLE);
        stop_hit = (state == S_STOP) && bit_hit;
`ifdef UART_RX_PARITY_EN
        frame_ok = rxd_s2 && !(^{shreg, par_bit});
`else
        frame_ok = rxd_s2;
`endif
        push_req  = stop_hit && frame_ok;
        bad_frame = stop_hit && !frame_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            if (state == S_IDLE || (state == S_START && half_hit) || bit_hit) cnt <= '0;
            else cnt <= cnt + CNT_ONE;
            if (state == S_START) bit_idx <= '0;
            if (state == S_DATA && bit_hit) begin
                shreg   <= {rxd_s2, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (state == S_PARITY && bit_hit) par_bit <= rxd_s2;
`endif
        end
    end

    // A pop in the push cycle frees the slot, so a full FIFO still accepts.
    assign full     = (occ == CNT_FULL);
    assign rx_valid = (occ != '0);
    assign pop      = rx_valid && rx_ready;
    assign push     = push_req && (!full || pop);
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      occ <= occ + OCC_ONE;
            else if (pop && !push) occ <= occ - OCC_ONE;
            frame_error <= bad_frame;
            overrun     <= push_req && full && !pop;
        end
    end
endmodule
